// File: rtl/fifo_pkg.sv
// Shared sizing for the read-side FIFO path: default widths and the pointer-width helper,
// so the FIFO, the read controller and the bench all derive identical sizes.
package fifo_pkg;

  localparam int FIFO_DATA_W = 8;
  localparam int FIFO_DEPTH  = 4;

  // Smallest r with 2**r >= n; evaluated at elaboration only.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W storage array for fifo_buffer: one synchronous write port,
// one combinational read port, contents deliberately not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int  DATA_W = FIFO_DATA_W,
  parameter int  DEPTH  = FIFO_DEPTH,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_buffer.sv
// Circular-buffer FIFO feeding the read-side controller. Optional sticky overflow/underflow
// flags are compiled in when FIFO_ERR_FLAGS_EN is defined.
module fifo_buffer
  import fifo_pkg::*;
#(
  parameter int  DATA_W = FIFO_DATA_W,
  parameter int  DEPTH  = FIFO_DEPTH,
  localparam int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
`ifdef FIFO_ERR_FLAGS_EN
  input  logic              clr_err,
  output logic              ovf_err,
  output logic              udf_err,
`endif
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE      = (ADDR_W + 1)'(1);

  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            push;
  logic            pop;

  // Handshake: a word moves on a rising edge when wr_valid && wr_ready; the producer holds
  // wr_valid/wr_data until then. rd_pop is a one-sided consume, ignored while empty.
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign wr_ready = ~full;
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
      if (push && !pop)      count <= count + ONE;
      else if (pop && !push) count <= count - ONE;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (wr_data),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_data)
  );

`ifdef FIFO_ERR_FLAGS_EN
  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
    end else begin
      if (wr_valid && full) ovf_err <= 1'b1;
      else if (clr_err)     ovf_err <= 1'b0;
      if (rd_pop && empty)  udf_err <= 1'b1;
      else if (clr_err)     udf_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// Bench for fifo_buffer: queue-based reference model, per-cycle compare at negedge,
// directed boundary cases with literal expectations, then randomized traffic.
module tb_fifo_buffer;
  import fifo_pkg::*;

  localparam int DW = FIFO_DATA_W;
  localparam int DP = FIFO_DEPTH;
  localparam int AW = clog2(DP);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_pop = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
  logic          clr_err = 1'b0;
  logic          ovf_err;
  logic          udf_err;
  bit            exp_ovf = 1'b0;
  bit            exp_udf = 1'b0;
`endif

  logic [DW-1:0] exp_q[$];
  int  total = 0;
  int  bad = 0;
  bit  check_en = 1'b0;

  fifo_buffer dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_data  (wr_data),
    .wr_ready (wr_ready),
    .rd_pop   (rd_pop),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
`ifdef FIFO_ERR_FLAGS_EN
    .clr_err  (clr_err),
    .ovf_err  (ovf_err),
    .udf_err  (udf_err),
`endif
    .count    (count)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: outputs compared against the queue model every cycle
  always @(negedge clk) begin
    if (check_en) begin
      chk("empty", int'(empty), int'(exp_q.size() == 0));
      chk("full", int'(full), int'(exp_q.size() == DP));
      chk("wr_ready", int'(wr_ready), int'(exp_q.size() < DP));
      chk("count", int'(count), exp_q.size());
      if (exp_q.size() > 0) chk("rd_data", int'(rd_data), int'(exp_q[0]));
`ifdef FIFO_ERR_FLAGS_EN
      chk("ovf_err", int'(ovf_err), int'(exp_ovf));
      chk("udf_err", int'(udf_err), int'(exp_udf));
`endif
    end
  end

  // Advance one clock edge and apply the FIFO rules to the model
  task automatic step();
    int  n;
    bit  push_ok;
    bit  pop_ok;
    @(posedge clk);
    n = exp_q.size();
    if (!rst) begin
      exp_q.delete();
`ifdef FIFO_ERR_FLAGS_EN
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
`endif
    end else begin
      push_ok = wr_valid && (n < DP);
      pop_ok  = rd_pop && (n > 0);
`ifdef FIFO_ERR_FLAGS_EN
      if (wr_valid && n == DP) exp_ovf = 1'b1;
      else if (clr_err)        exp_ovf = 1'b0;
      if (rd_pop && n == 0)    exp_udf = 1'b1;
      else if (clr_err)        exp_udf = 1'b0;
`endif
      if (pop_ok)  void'(exp_q.pop_front());
      if (push_ok) exp_q.push_back(wr_data);
    end
    #1;
  endtask

  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic p);
    wr_valid = v;
    wr_data  = d;
    rd_pop   = p;
    step();
  endtask

  task automatic drain();
    for (int i = 0; i < DP + 1; i++) cycle(1'b0, '0, 1'b1);
  endtask

  initial begin
    logic          v;
    logic [DW-1:0] d;
    logic          p;

    // Reset
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    check_en = 1'b1;
    @(negedge clk);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_wr_ready", int'(wr_ready), 1);
    chk("rst_count", int'(count), 0);

    // Pop while empty is ignored
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);
    @(negedge clk);
    chk("empty_pop_count", int'(count), 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("udf_set", int'(udf_err), 1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
`endif

    // Fill with 11..44
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, DW'(8'h11 * (i + 1)), 1'b0);
      @(negedge clk);
      chk("fill_count", int'(count), i + 1);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_wr_ready", int'(wr_ready), 0);

    // Write while full is refused
    cycle(1'b1, 8'h55, 1'b0);
    @(negedge clk);
    chk("ovf_count", int'(count), 4);
    chk("ovf_head", int'(rd_data), 8'h11);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_set", int'(ovf_err), 1);
    wr_valid = 1'b0;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
`endif

    // Drain in order
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("drain_data", int'(rd_data), 8'h11 * (i + 1));
      cycle(1'b0, '0, 1'b1);
    end
    @(negedge clk);
    chk("drain_empty", int'(empty), 1);
    chk("drain_count", int'(count), 0);

    // Wrap-around with count held at 1
    cycle(1'b1, 8'hA0, 1'b0);
    for (int i = 1; i < 6; i++) begin
      @(negedge clk);
      chk("wrap_data", int'(rd_data), 8'hA0 + i - 1);
      chk("wrap_count", int'(count), 1);
      cycle(1'b1, DW'(8'hA0 + i), 1'b1);
    end
    @(negedge clk);
    chk("wrap_last", int'(rd_data), 8'hA5);
    cycle(1'b0, '0, 1'b1);

    // Simultaneous push/pop at count=2
    cycle(1'b1, 8'hB0, 1'b0);
    cycle(1'b1, 8'hB1, 1'b0);
    cycle(1'b1, 8'hB2, 1'b1);
    @(negedge clk);
    chk("pp2_count", int'(count), 2);
    chk("pp2_head", int'(rd_data), 8'hB1);
    drain();

    // Full with pop and write together: write lands one cycle later
    for (int i = 0; i < 4; i++) cycle(1'b1, DW'(8'hC0 + i), 1'b0);
    cycle(1'b1, 8'hC4, 1'b1);
    @(negedge clk);
    chk("fullpp_count", int'(count), 3);
    chk("fullpp_head", int'(rd_data), 8'hC1);
    cycle(1'b1, 8'hC4, 1'b0);
    @(negedge clk);
    chk("fullpp_late_count", int'(count), 4);
    drain();

    // Empty with push and pop together
    cycle(1'b1, 8'hD0, 1'b1);
    @(negedge clk);
    chk("emptypp_count", int'(count), 1);
    chk("emptypp_data", int'(rd_data), 8'hD0);
    drain();
`ifdef FIFO_ERR_FLAGS_EN
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
`endif

    // Asynchronous reset mid-cycle with count=3, write pending
    for (int i = 0; i < 3; i++) cycle(1'b1, DW'(8'hE0 + i), 1'b0);
    wr_data = 8'hEE;
    #3;
    rst = 1'b0;
    exp_q.delete();
`ifdef FIFO_ERR_FLAGS_EN
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
`endif
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    cycle(1'b1, 8'hEE, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0);
    rst = 1'b1;
    cycle(1'b1, 8'hF0, 1'b0);
    @(negedge clk);
    chk("post_rst_count", int'(count), 1);
    chk("post_rst_data", int'(rd_data), 8'hF0);
    drain();

    // Randomized traffic; producer holds a refused word
    for (int i = 0; i < 400; i++) begin
      if (!(wr_valid && exp_q.size() == DP)) begin
        v = 1'($urandom_range(0, 1));
        d = DW'($urandom_range(0, 255));
      end else begin
        v = wr_valid;
        d = wr_data;
      end
      if (i < 200) p = ($urandom_range(0, 2) == 0);
      else         p = ($urandom_range(0, 2) != 0);
`ifdef FIFO_ERR_FLAGS_EN
      clr_err = ($urandom_range(0, 7) == 0);
`endif
      cycle(v, d, p);
    end
    cycle(1'b0, '0, 1'b0);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
